// File: rtl/fakeram_arb_pkg.sv
// Shared types for the fakeram130 register-file arbiter.
// Default sizing matches the fakeram130_2x576 macro.
package fakeram_arb_pkg;

    localparam int BITS       = 2;
    localparam int WORD_DEPTH = 576;
    localparam int ADDR_WIDTH = 10;

    typedef logic port_idx_t;

    typedef struct packed {
        logic                  ce;
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [BITS-1:0]       wd;
        logic [BITS-1:0]       wm;
    } ram_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// Priority flips to the other port after each transfer.
module rr_arb2
    import fakeram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    port_idx_t prio;

    always_comb begin
        gnt = 2'b00;
        if (rst_n && en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = prio ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (|gnt) begin
            prio <= ~gnt[1];
        end
    end

endmodule

// File: rtl/fakeram130_rf_arbiter.sv
// Shares one single-port fakeram130 macro between two requesters,
// with range checking and a one-cycle read response.
module fakeram130_rf_arbiter #(
    parameter int BITS       = fakeram_arb_pkg::BITS,
    parameter int WORD_DEPTH = fakeram_arb_pkg::WORD_DEPTH,
    parameter int ADDR_WIDTH = fakeram_arb_pkg::ADDR_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [BITS-1:0]       wd0,
    input  logic [BITS-1:0]       wd1,
    input  logic [BITS-1:0]       wm0,
    input  logic [BITS-1:0]       wm1,
    output logic [1:0]            gnt,
    output logic [1:0]            rvalid,
    output logic                  rerr,
    output logic [BITS-1:0]       rdata,
    output logic [CNT_WIDTH-1:0]  conflicts,
    output logic                  ram_ce,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [BITS-1:0]       ram_wd,
    output logic [BITS-1:0]       ram_wm,
    input  logic [BITS-1:0]       ram_rd
);

    import fakeram_arb_pkg::port_idx_t;

    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(WORD_DEPTH);

    typedef struct packed {
        logic                  ce;
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [BITS-1:0]       wd;
        logic [BITS-1:0]       wm;
    } ram_bus_t;

    port_idx_t             k;
    logic                  xfer;
    logic                  rd_xfer;
    logic                  in_range;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [BITS-1:0]       sel_wd;
    logic [BITS-1:0]       sel_wm;
    ram_bus_t              bus;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .req   (req),
        .gnt   (gnt)
    );

    assign k        = gnt[1];
    assign xfer     = |gnt;
    assign sel_we   = k ? we[1] : we[0];
    assign sel_addr = k ? addr1 : addr0;
    assign sel_wd   = k ? wd1 : wd0;
    assign sel_wm   = k ? wm1 : wm0;
    assign in_range = {1'b0, sel_addr} < DEPTH;
    assign rd_xfer  = xfer && !sel_we;

    // Out-of-range accesses are granted but never reach the macro.
    always_comb begin
        bus = '0;
        if (xfer && in_range) begin
            bus.ce   = 1'b1;
            bus.we   = sel_we;
            bus.addr = sel_addr;
            bus.wd   = sel_wd;
            bus.wm   = sel_wm;
        end
    end

    assign ram_ce   = bus.ce;
    assign ram_we   = bus.we;
    assign ram_addr = bus.addr;
    assign ram_wd   = bus.wd;
    assign ram_wm   = bus.wm;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid    <= 2'b00;
            rerr      <= 1'b0;
            conflicts <= '0;
        end else begin
            rvalid <= rd_xfer ? (k ? 2'b10 : 2'b01) : 2'b00;
            rerr   <= rd_xfer && !in_range;
            if (en && req == 2'b11 && !(&conflicts)) begin
                conflicts <= conflicts + CNT_WIDTH'(1);
            end
        end
    end

    assign rdata = (|rvalid && !rerr) ? ram_rd : '0;

endmodule
